// File: rtl/imm_gen_if.sv
// Bundle between the main decoder and the immediate generator: instruction
// field and format select in, registered immediate and illegal-format flag out.
interface imm_gen_if;
   // No handshake: the slave samples imm/ImmSrc on every rising clock edge and
   // presents the decode on ImmExt/ImmErr until the following edge.
   logic [24:0] imm;
   logic [2:0]  ImmSrc;
   logic [31:0] ImmExt;
   logic        ImmErr;

   modport master (
      output imm,
      output ImmSrc,
      input  ImmExt,
      input  ImmErr
   );

   modport slave (
      input  imm,
      input  ImmSrc,
      output ImmExt,
      output ImmErr
   );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes instr[31:7] by format into a registered
// 32-bit immediate with a registered flag for illegal format codes.
module imm_gen (
   input  logic       clk,
   input  logic       rst_n,
   imm_gen_if.slave   bus
);

   localparam logic [2:0] SRC_I = 3'b000;
   localparam logic [2:0] SRC_S = 3'b001;
   localparam logic [2:0] SRC_B = 3'b101;
   localparam logic [2:0] SRC_U = 3'b010;
   localparam logic [2:0] SRC_J = 3'b110;

   logic [31:0] imm_ext_d, imm_ext_q;
   logic        imm_err_d, imm_err_q;
   logic        sign;

   assign sign = bus.imm[24];

   always_comb begin
      imm_ext_d = 32'h0000_0000;
      imm_err_d = 1'b0;
      case (bus.ImmSrc)
         SRC_I: imm_ext_d = {{20{sign}}, bus.imm[24:13]};
         SRC_S: imm_ext_d = {{20{sign}}, bus.imm[24:18], bus.imm[4:0]};
         SRC_B: imm_ext_d = {{19{sign}}, sign, bus.imm[0], bus.imm[23:18],
                             bus.imm[4:1], 1'b0};
         SRC_U: imm_ext_d = {bus.imm[24:5], 12'h000};
         SRC_J: imm_ext_d = {{11{sign}}, sign, bus.imm[12:5], bus.imm[13],
                             bus.imm[23:14], 1'b0};
         // Illegal codes and any unknown select decode to zero with the flag set.
         default: begin
            imm_ext_d = 32'h0000_0000;
            imm_err_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         imm_ext_q <= 32'h0000_0000;
         imm_err_q <= 1'b0;
      end else begin
         imm_ext_q <= imm_ext_d;
         imm_err_q <= imm_err_d;
      end
   end

   assign bus.ImmExt = imm_ext_q;
   assign bus.ImmErr = imm_err_q;

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: directed vector table, mid-cycle glitch sequence, and a
// randomized sweep scored against an instruction-level immediate model.
module tb_imm_gen;

   logic clk;
   logic rst_n;

   imm_gen_if bus ();

   imm_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   typedef struct {
      logic        rst_n;
      logic [24:0] imm;
      logic [2:0]  src;
      logic [31:0] exp_ext;
      logic        exp_err;
   } vec_t;

   vec_t vecs[16];

   logic [32:0] exp_q[$];

   // ---------------- reference model ----------------
   // Rebuilds the instruction word and applies the ISA immediate definitions,
   // sign-extending by subtracting 2^width when the field's top bit is set.
   function automatic logic [32:0] ref_model(input logic [24:0] f, input logic [2:0] src);
      logic [31:0] instr;
      longint      v;
      logic        err;
      instr = {f, 7'b0000000};
      v     = 0;
      err   = 1'b0;
      case (src)
         3'b000: begin
            v = longint'(instr[31:20]);
            if (instr[31]) v = v - 4096;
         end
         3'b001: begin
            v = longint'({instr[31:25], instr[11:7]});
            if (instr[31]) v = v - 4096;
         end
         3'b101: begin
            v = longint'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            if (instr[31]) v = v - 8192;
         end
         3'b010: v = longint'(instr[31:12]) * 4096;
         3'b110: begin
            v = longint'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
            if (instr[31]) v = v - 2097152;
         end
         default: begin
            v   = 0;
            err = 1'b1;
         end
      endcase
      return {err, v[31:0]};
   endfunction

   // ---------------- driver / checker ----------------
   task automatic drive(input logic r, input logic [24:0] f, input logic [2:0] src);
      rst_n      = r;
      bus.imm    = f;
      bus.ImmSrc = src;
   endtask

   task automatic check(input string name, input logic [31:0] exp_ext, input logic exp_err);
      n_vec++;
      if (bus.ImmExt !== exp_ext || bus.ImmErr !== exp_err) begin
         n_err++;
         $display("FAIL %s: got ImmExt=%08h ImmErr=%0b, expected ImmExt=%08h ImmErr=%0b",
                  name, bus.ImmExt, bus.ImmErr, exp_ext, exp_err);
      end
   endtask

   // Apply inputs, let one edge pass, then sample 1 time unit after it.
   task automatic step_check(input string name, input logic r, input logic [24:0] f,
                             input logic [2:0] src, input logic [31:0] exp_ext,
                             input logic exp_err);
      drive(r, f, src);
      @(posedge clk);
      #1;
      check(name, exp_ext, exp_err);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [24:0] f;
      logic [2:0]  src;
      logic        r;
      logic [32:0] e;

      n_vec = 0;
      n_err = 0;
      drive(1'b0, 25'h1FF_FFFF, 3'b000);

      vecs[0]  = '{1'b0, 25'h1FF_FFFF, 3'b000, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 25'h1FF_FFFF, 3'b000, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b1, 25'h1FF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0};
      vecs[3]  = '{1'b1, 25'b0000000011110000000000000, 3'b000, 32'h0000_000F, 1'b0};
      vecs[4]  = '{1'b1, 25'b1000000000000000000000010, 3'b001, 32'hFFFF_F802, 1'b0};
      vecs[5]  = '{1'b1, 25'b0000001000000000000000010, 3'b101, 32'h0000_0022, 1'b0};
      vecs[6]  = '{1'b1, 25'b0000000000000000000100000, 3'b010, 32'h0000_1000, 1'b0};
      vecs[7]  = '{1'b1, 25'b0000000000100000000100000, 3'b110, 32'h0000_1002, 1'b0};
      vecs[8]  = '{1'b1, 25'h100_0000, 3'b110, 32'hFFF0_0000, 1'b0};
      vecs[9]  = '{1'b1, 25'h1FF_FFFF, 3'b011, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b1, 25'h1FF_FFFF, 3'b100, 32'h0000_0000, 1'b1};
      vecs[11] = '{1'b1, 25'h1FF_FFFF, 3'b111, 32'h0000_0000, 1'b1};
      vecs[12] = '{1'b1, 25'h1FF_FFFF, 3'b010, 32'hFFFF_F000, 1'b0};
      vecs[13] = '{1'b1, 25'h1FF_FFFF, 3'b101, 32'hFFFF_FFFE, 1'b0};
      vecs[14] = '{1'b1, 25'h1FF_FFFF, 3'b001, 32'hFFFF_FFFF, 1'b0};
      vecs[15] = '{1'b1, 25'h0FF_FFFF, 3'b110, 32'h000F_FFFE, 1'b0};

      for (int i = 0; i < 16; i++) begin
         step_check($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].imm, vecs[i].src,
                    vecs[i].exp_ext, vecs[i].exp_err);
      end

      // Mid-cycle input changes must not reach the outputs before the next edge.
      step_check("glitch_load", 1'b1, 25'h1FF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0);
      #2;
      drive(1'b1, 25'h000_0000, 3'b011);
      #1;
      check("glitch_hold", 32'hFFFF_FFFF, 1'b0);
      @(posedge clk);
      #1;
      check("glitch_next", 32'h0000_0000, 1'b1);

      // Reset mid-stream clears immediately; release loads without warm-up.
      step_check("mid_rst", 1'b0, 25'h1FF_FFFF, 3'b110, 32'h0000_0000, 1'b0);
      step_check("rst_release", 1'b1, 25'h1FF_FFFF, 3'b110, 32'hFFFF_FFFE, 1'b0);

      // Back-to-back sweep through all codes with a reset pulse in the middle.
      for (int i = 0; i < 64; i++) begin
         f   = 25'($urandom);
         src = 3'(i % 8);
         r   = (i == 29) ? 1'b0 : 1'b1;
         drive(r, f, src);
         exp_q.push_back(r ? ref_model(f, src) : 33'd0);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("sweep%0d", i), e[31:0], e[32]);
      end

      // Fully random formats and fields.
      for (int i = 0; i < 200; i++) begin
         f   = 25'($urandom);
         src = 3'($urandom_range(0, 7));
         r   = ($urandom_range(0, 19) != 0);
         drive(r, f, src);
         exp_q.push_back(r ? ref_model(f, src) : 33'd0);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("rand%0d", i), e[31:0], e[32]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
